uart_tx_ctrl: RTL
=================

// Module: uart_tx_ctrl
// PURPOSE
//   Parametrised UART transmit controller: serialises one frame per accepted word as
//   start bit, DATA_W data bits LSB-first, optional parity bit, then 1 or 2 stop bits.
//   Bit timing comes from an internal runtime-programmable baud divider.
//   Sits between the CPU-side UART register block (valid/ready) and the tx pad.
// PARAMETERS
//   DATA_W   8   data bits per frame, legal 5..9
//   DIV_W    16  width of the baud divisor; cycles per bit = baud_div_i (0 treated as 1)
// PORTS
//   clk_i          in   1       clock, all logic on rising edge
//   rst_ni         in   1       asynchronous active-low reset
//   en_i           in   1       global enable; 0 freezes state, counters, tx_o
//   baud_div_i     in   DIV_W   clock cycles per bit
//   parity_i       in   2       00 none, 01 even, 10 odd, 11 = none
//   stop2_i        in   1       1 = two stop bits, 0 = one
//   tx_valid_i     in   1       word available on tx_data_i
//   tx_data_i      in   DATA_W  word to send
//   tx_ready_o     out  1       controller can accept a word this cycle
//   tx_o           out  1       serial line, idle high
//   busy_o         out  1       frame in progress (state != IDLE)
//   done_o         out  1       one-cycle pulse at end of final stop bit
// BEHAVIOUR
//   - Reset (rst_ni=0, async): state IDLE, tx_o=1, busy_o=0, done_o=0, counters 0;
//     mid-frame reset aborts the frame immediately, line returns high same instant.
//   - tx_ready_o = en_i & (state==IDLE | last cycle of last stop bit). Accept = valid & ready.
//   - On accept: latch tx_data_i, baud_div_i, parity_i, stop2_i; later input changes
//     are ignored until the next accept. Parity computed from latched data.
//   - FSM: IDLE -> START -> DATA(DATA_W bits) -> PARITY (only if enabled) -> STOP
//     (1 or 2 bits) -> IDLE, or -> START directly if a new word is accepted in the
//     last stop cycle (back-to-back, zero idle gap).
//   - Latency: tx_o drives 0 (start bit) the cycle after accept.
//   - Each bit holds exactly D = max(baud_div_i,1) enabled cycles; baud counter
//     counts 0..D-1, bit advances on wrap. Bit counter wraps at DATA_W-1 / stop count.
//   - Frame length = D*(1+DATA_W+P+S) enabled cycles, P in {0,1}, S in {1,2}.
//   - Parity bit: even -> ^data; odd -> ~^data.
//   - done_o pulses in the final cycle of the last stop bit, coincident with the
//     back-to-back accept window; done_o=0 whenever en_i=0.
//   - en_i=0: no state/counter advance, tx_o holds its value, tx_ready_o=0;
//     resuming continues exactly where frozen (bit widths stretched, not corrupted).
//   - tx_valid_i while busy (not last stop cycle): ignored, not accepted.
// TESTING
//   DATA_W=8, div=4, parity none, 1 stop, send 0x55 -> tx_o 0,1,0,1,0,1,0,1,0,1 each 4 cyc, 40 cyc frame, done_o at cyc 40.
//   div=2, even parity, send 0x07 -> parity bit 1; odd parity send 0x07 -> parity bit 0; frame 22 cyc.
//   stop2_i=1, div=3, send 0xA3 -> two stop bits high 6 cyc, frame 33 cyc; busy_o low after.
//   valid held with 0x11 then 0x22, div=1 -> second start bit the cycle after first done_o, no idle gap.
//   en_i low 5 cyc during data bit 3 (div=4) -> that bit lasts 9 cyc, rest of frame unchanged.
//   rst_ni low mid data bit 2, then send 0x0F with baud_div_i=0 -> tx_o=1 at reset; new frame 1 cyc/bit, 10 cyc.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: one frame per accepted word.
// Frame = start bit, DATA_W data bits LSB-first, optional parity, 1 or 2 stop bits.
// Bit time is a latched, runtime-programmable divisor. en_i freezes everything in place.
module uart_tx_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  baud_div_i,
  input  logic [1:0]        parity_i,
  input  logic              stop2_i,
  input  logic              tx_valid_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              tx_ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Per-frame settings captured at accept; inputs are free to change afterwards.
  // data doubles as the shift register, so bit 0 is always the bit on the line.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DIV_W-1:0]  div;
    logic              par_en;
    logic              par_bit;
    logic              stop2;
  } frame_t;

  state_t            state_q, state_d;
  frame_t            cfg_q, cfg_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic [BW-1:0]     bit_q, bit_d;

  logic bit_wrap;
  logic last_stop;
  logic accept;

  // div is never zero once latched, so div-1 is the last cycle of a bit.
  assign bit_wrap   = (baud_q == cfg_q.div - DIV_W'(1));
  assign last_stop  = (state_q == S_STOP) && bit_wrap &&
                      (bit_q == (cfg_q.stop2 ? BW'(1) : BW'(0)));

  // Ready in idle or in the very last stop cycle, which gives zero-gap back-to-back frames.
  assign tx_ready_o = en_i & ((state_q == S_IDLE) | last_stop);
  assign accept     = tx_valid_i & tx_ready_o;
  assign done_o     = en_i & last_stop;
  assign busy_o     = (state_q != S_IDLE);

  // State, counters and latched frame settings; reset forces the line idle instantly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      cfg_q     <= '0;
      cfg_q.div <= DIV_W'(1);
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      cfg_q   <= cfg_d;
    end
  end

  // Next-state, counter advance and line value; nothing moves while en_i is low.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    cfg_d   = cfg_q;

    if (en_i) begin
      if (accept) begin
        state_d       = S_START;
        baud_d        = '0;
        bit_d         = '0;
        cfg_d.data    = tx_data_i;
        cfg_d.div     = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
        cfg_d.par_en  = (parity_i == 2'b01) || (parity_i == 2'b10);
        cfg_d.par_bit = (parity_i == 2'b10) ? ~^tx_data_i : ^tx_data_i;
        cfg_d.stop2   = stop2_i;
      end else if (state_q != S_IDLE) begin
        if (!bit_wrap) begin
          baud_d = baud_q + DIV_W'(1);
        end else begin
          baud_d = '0;
          unique case (state_q)
            S_START: begin
              state_d = S_DATA;
              bit_d   = '0;
            end
            S_DATA: begin
              cfg_d.data = cfg_q.data >> 1;
              if (bit_q == BW'(DATA_W - 1)) begin
                state_d = cfg_q.par_en ? S_PARITY : S_STOP;
                bit_d   = '0;
              end else begin
                bit_d = bit_q + BW'(1);
              end
            end
            S_PARITY: begin
              state_d = S_STOP;
              bit_d   = '0;
            end
            S_STOP: begin
              if (last_stop) begin
                state_d = S_IDLE;
                bit_d   = '0;
              end else begin
                bit_d = bit_q + BW'(1);
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end

    unique case (state_q)
      S_START:  tx_o = 1'b0;
      S_DATA:   tx_o = cfg_q.data[0];
      S_PARITY: tx_o = cfg_q.par_bit;
      default:  tx_o = 1'b1;
    endcase
  end

endmodule
